des_result_writer: RTL and testbench

Avalon-MM write-back master that drains 64-bit DES/3DES ciphertext blocks from the encryption output stage and stores each block to SDRAM as two consecutive 32-bit words. It sits directly downstream of the ECC/3DES core's output FIFO. It runs a CSR-programmed job: base address plus block count. It reports progress and completion back to the CSR bank.

---
 rtl/des_result_writer.sv | 120 ++++++++++++
 tb/tb_des_result_writer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_result_writer.sv
// Purpose: drain 64-bit DES/3DES ciphertext blocks and store each to SDRAM as two Avalon-MM words (high word first).
// Latency: handshake at N -> high word in N+1, low word in N+2, next in_ready or done in N+3 (no waitrequest).
// Backpressure: in_ready only in WAIT_DATA; master_waitrequest holds the current word stable, one cycle per stall.
module des_result_writer #(
  parameter int ADDRESSWIDTH = 26,
  parameter int DATAWIDTH    = 32,
  parameter int COUNTWIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDRESSWIDTH-1:0] base_addr,
  input  logic [COUNTWIDTH-1:0]   block_limit,
  input  logic [63:0]             in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [ADDRESSWIDTH-1:0] master_address,
  output logic [DATAWIDTH-1:0]    master_writedata,
  output logic                    master_write,
  input  logic                    master_waitrequest,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic [COUNTWIDTH-1:0]   blocks_written
);

  typedef enum logic [1:0] {IDLE, WAIT_DATA, WR_HI, WR_LO} state_t;

  localparam logic [ADDRESSWIDTH-1:0] WORD_STEP  = ADDRESSWIDTH'(4);
  localparam logic [ADDRESSWIDTH-1:0] BLOCK_STEP = ADDRESSWIDTH'(8);

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDRESSWIDTH-1:0] ptr;
  logic [COUNTWIDTH-1:0]   limit;
  logic [63:0]             blk;
  logic [COUNTWIDTH-1:0]   bw_next;

  // Completion is judged on the count including the block just finished.
  assign bw_next = blocks_written + COUNTWIDTH'(1);

  // Next-state and bus outputs; outputs depend on state only, never on in_valid.
  always_comb begin
    state_nxt        = state;
    in_ready         = 1'b0;
    master_write     = 1'b0;
    master_address   = '0;
    master_writedata = '0;
    busy             = (state != IDLE);
    case (state)
      IDLE: begin
        if (start && (block_limit != '0)) state_nxt = WAIT_DATA;
      end
      WAIT_DATA: begin
        in_ready = 1'b1;
        // abort wins over a same-cycle handshake
        if (abort)         state_nxt = IDLE;
        else if (in_valid) state_nxt = WR_HI;
      end
      WR_HI: begin
        master_write     = 1'b1;
        master_address   = ptr;
        master_writedata = blk[63:32];
        if (!master_waitrequest) state_nxt = WR_LO;
      end
      WR_LO: begin
        master_write     = 1'b1;
        master_address   = ptr + WORD_STEP;
        master_writedata = blk[31:0];
        if (!master_waitrequest) begin
          if (abort || (bw_next == limit)) state_nxt = IDLE;
          else                             state_nxt = WAIT_DATA;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Job registers: pointer, limit, captured block and sticky status flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      ptr            <= '0;
      limit          <= '0;
      blk            <= '0;
      done           <= 1'b0;
      aborted        <= 1'b0;
      blocks_written <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            ptr            <= {base_addr[ADDRESSWIDTH-1:3], 3'b000};
            limit          <= block_limit;
            done           <= (block_limit == '0);
            aborted        <= 1'b0;
            blocks_written <= '0;
          end
        end
        WAIT_DATA: begin
          if (abort)         aborted <= 1'b1;
          else if (in_valid) blk     <= in_data;
        end
        WR_LO: begin
          // abort is only honoured here so a block is never split
          if (!master_waitrequest) begin
            ptr            <= ptr + BLOCK_STEP;
            blocks_written <= bw_next;
            if (abort)                 aborted <= 1'b1;
            else if (bw_next == limit) done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_des_result_writer.sv
// Purpose: randomized scoreboard bench for des_result_writer against a job-level address/data model.
// Latency: checks 3-cycle block latency unstalled and 9 cycles with three waitrequest cycles per word.
// Backpressure: waitrequest driven off, random, or as a fixed 3-cycle stall per word.
module tb_des_result_writer;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] block_limit;
  logic [63:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] master_address;
  logic [DW-1:0] master_writedata;
  logic          master_write;
  logic          master_waitrequest;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [CW-1:0] blocks_written;

  des_result_writer #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW), .COUNTWIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .base_addr(base_addr), .block_limit(block_limit),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .master_address(master_address), .master_writedata(master_writedata),
    .master_write(master_write), .master_waitrequest(master_waitrequest),
    .busy(busy), .done(done), .aborted(aborted), .blocks_written(blocks_written)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  int            tests = 0;
  int            fails = 0;
  int            wmode = 0;   // 0: no stall, 1: random stall, 2: 3 stall cycles per word
  logic [AW-1:0] job_base;
  int            job_k;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Waitrequest generator, decided just after each rising edge.
  initial begin
    int stall_cnt;
    stall_cnt = 0;
    master_waitrequest = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (wmode)
        1: master_waitrequest = ($urandom_range(0, 2) == 0);
        2: begin
          if (master_write && stall_cnt < 3) begin
            master_waitrequest = 1'b1;
            stall_cnt++;
          end else begin
            master_waitrequest = 1'b0;
            stall_cnt = 0;
          end
        end
        default: master_waitrequest = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted write, checks stall stability and idle bus.
  initial begin
    logic          prev_stall;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_data;
    wr_t           e;
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_write_held", master_write, 1'b1);
          check("stall_addr_stable", master_address, prev_addr);
          check("stall_data_stable", master_writedata, prev_data);
        end
        if (master_write && !master_waitrequest) begin
          if (exp_q.size() == 0) begin
            check("unexpected_write", {master_address, master_writedata}, 64'hDEAD);
          end else begin
            e = exp_q.pop_front();
            check("write_addr", master_address, e.addr);
            check("write_data", master_writedata, e.data);
          end
        end else if (!master_write) begin
          check("idle_bus_zero", {master_address, master_writedata}, 64'h0);
        end
        prev_stall = master_write && master_waitrequest;
        prev_addr  = master_address;
        prev_data  = master_writedata;
      end
    end
  end

  task automatic start_job(input logic [AW-1:0] base, input logic [CW-1:0] lim);
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; block_limit = lim;
    job_base = {base[AW-1:3], 3'b000};
    job_k = 0;
    @(posedge clk); #1;
    start = 1'b0; base_addr = AW'($urandom); block_limit = CW'($urandom);
    @(negedge clk);
    check("start_busy", busy, lim != 0);
    check("start_in_ready", in_ready, lim != 0);
    check("start_done", done, lim == 0);
    check("start_aborted", aborted, 1'b0);
    check("start_blocks", blocks_written, 0);
  endtask

  task automatic send_block(input logic [63:0] d);
    int  ok;
    wr_t w;
    @(posedge clk); #1;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = d;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (ok == 1) begin
      w.addr = job_base + AW'(8 * job_k);           w.data = d[63:32]; exp_q.push_back(w);
      w.addr = job_base + AW'(8 * job_k) + AW'(4);  w.data = d[31:0];  exp_q.push_back(w);
      job_k++;
    end else begin
      check("handshake_timeout", 0, 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      cyc++;
      if (!busy) break;
    end
    if (busy) check("idle_timeout", busy, 1'b0);
  endtask

  task automatic end_check(input string tag, input logic exp_done, input logic exp_ab);
    check({tag, "_done"}, done, exp_done);
    check({tag, "_aborted"}, aborted, exp_ab);
    check({tag, "_blocks"}, blocks_written, job_k);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic count_ready(input string tag);
    int n;
    n = 0;
    in_valid = 1'b1;
    repeat (5) begin @(negedge clk); if (in_ready) n++; end
    check(tag, n, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run", tests);
    $fatal(1);
  end

  initial begin
    int lat;
    int ok;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; block_limit = '0;
    in_data = '0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_write", master_write, 1'b0);
    check("rst_bus", {master_address, master_writedata}, 64'h0);
    check("rst_flags", {busy, done, aborted}, 3'b000);
    check("rst_blocks", blocks_written, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Basic two-block job, no stalls.
    wmode = 0;
    start_job(26'h0200000, 2);
    send_block(64'h1111111122222222);
    send_block(64'h3333333344444444);
    wait_idle(lat);
    check("basic_latency", lat, 3);
    end_check("basic", 1'b1, 1'b0);

    // Fixed 3-cycle stall per word; a mid-job start must be ignored.
    wmode = 2;
    start_job(AW'($urandom), 2);
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'($urandom); block_limit = 1;
    @(posedge clk); #1;
    start = 1'b0;
    send_block({$urandom, $urandom});
    send_block({$urandom, $urandom});
    wait_idle(lat);
    check("stall_latency", lat, 9);
    end_check("stall", 1'b1, 1'b0);

    // Zero-length job.
    wmode = 0;
    start_job(AW'($urandom), 0);
    count_ready("zero_in_ready");
    end_check("zero", 1'b1, 1'b0);

    // Abort during WR_HI of block 1 of a 4-block job.
    start_job(AW'($urandom), 4);
    send_block({$urandom, $urandom});
    send_block({$urandom, $urandom});
    abort = 1'b1;
    wait_idle(lat);
    end_check("abort_wr", 1'b0, 1'b1);
    count_ready("abort_in_ready");
    abort = 1'b0;

    // Abort in WAIT_DATA with in_valid high: block must not be taken.
    wmode = 1;
    start_job(AW'($urandom), 3);
    send_block({$urandom, $urandom});
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    check("abort_wait_reached", ok, 1);
    abort = 1'b1; in_valid = 1'b1; in_data = {$urandom, $urandom};
    @(negedge clk);
    check("abort_wait_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    end_check("abort_wait", 1'b0, 1'b1);

    // Misaligned base near the top of the address space wraps to 0.
    start_job(26'h3FFFFFB, 2);
    send_block({$urandom, $urandom});
    send_block({$urandom, $urandom});
    wait_idle(lat);
    end_check("wrap", 1'b1, 1'b0);

    // Reset in the middle of a stalled write.
    wmode = 2;
    start_job(AW'($urandom), 3);
    send_block({$urandom, $urandom});
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (master_write && master_waitrequest) begin ok = 1; break; end
    end
    check("reset_stall_reached", ok, 1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("reset_mid_write", master_write, 1'b0);
    check("reset_mid_bus", {master_address, master_writedata}, 64'h0);
    check("reset_mid_flags", {busy, done, aborted, in_ready}, 4'b0000);
    check("reset_mid_blocks", blocks_written, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Random jobs.
    for (int j = 0; j < 8; j++) begin
      int lim;
      wmode = $urandom_range(0, 2);
      lim = $urandom_range(1, 5);
      start_job(AW'($urandom), CW'(lim));
      for (int b = 0; b < lim; b++) send_block({$urandom, $urandom});
      wait_idle(lat);
      end_check("rand", 1'b1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
